clk_div_ctrl: RTL and testbench



---
 rtl/clk_div_pkg.sv | 22 ++
 rtl/clk_div_counter.sv | 83 ++++++++
 rtl/clk_div_ctrl.sv | 149 ++++++++++++++
 tb/tb_clk_div_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the runtime-programmable clock divider.
package clk_div_pkg;

    // Default width of the divisor and period counter
    localparam int CNT_W_DEF = 16;

    // Smallest divisor that still yields a real high and low phase
    localparam logic [31:0] MIN_DIV = 32'd2;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // True when a requested divisor is usable (zero-extended to 32 bits by the caller)
    function automatic logic div_ok(input logic [31:0] d);
        return (d >= MIN_DIV);
    endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Period counter: produces cnt, the registered divided clock and the
// rising-edge strobe for the divisor currently in effect.
module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run,
    input  logic             run_next,
    input  logic [CNT_W-1:0] div,
    output logic             wrap,
    output logic [CNT_W-1:0] cnt,
    output logic             clk_out,
    output logic             tick_out
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;
    logic             clk_r;
    logic             tick_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] half_s;
    logic             wrap_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             clk_nxt_s;
    logic             tick_nxt_s;

    // Period boundary detection and helper values for the next-count logic
    always_comb begin
        cnt_inc_s = cnt_r + ONE;
        half_s    = div >> 1;
        wrap_s    = run && (cnt_r == (div - ONE));
    end

    // Next count, divided clock level and strobe for the coming cycle
    always_comb begin
        cnt_nxt_s  = '0;
        clk_nxt_s  = 1'b0;
        tick_nxt_s = 1'b0;
        if (!run_next) begin
            // Idle (or stopping at the end of a drain): parked low at zero
            cnt_nxt_s  = '0;
            clk_nxt_s  = 1'b0;
            tick_nxt_s = 1'b0;
        end else if (!run) begin
            // Starting from idle: first period begins immediately
            cnt_nxt_s  = '0;
            clk_nxt_s  = 1'b1;
            tick_nxt_s = 1'b1;
        end else if (wrap_s) begin
            // New period; cnt 0 is always in the high half since div >= 2
            cnt_nxt_s  = '0;
            clk_nxt_s  = 1'b1;
            tick_nxt_s = 1'b1;
        end else begin
            cnt_nxt_s  = cnt_inc_s;
            clk_nxt_s  = (cnt_inc_s < half_s);
            tick_nxt_s = 1'b0;
        end
    end

    // Counter and output registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            clk_r  <= 1'b0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            clk_r  <= clk_nxt_s;
            tick_r <= tick_nxt_s;
        end
    end

    assign wrap     = wrap_s;
    assign cnt      = cnt_r;
    assign clk_out  = clk_r;
    assign tick_out = tick_r;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock divider controller: run/drain sequencing, divisor handshake with a
// one-deep pending register, and boundary-aligned divisor updates.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en_in,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_valid_in,
    output logic             div_ready_out,
    output logic [CNT_W-1:0] div_cur_out,
    output logic             clk_out,
    output logic             tick_out,
    output logic             busy_out,
    output logic             err_out
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             pending_r;
    logic             pending_nxt_s;
    logic [CNT_W-1:0] pend_div_r;
    logic [CNT_W-1:0] pend_div_nxt_s;
    logic [CNT_W-1:0] div_cur_r;
    logic [CNT_W-1:0] div_cur_nxt_s;
    logic             ready_r;
    logic             err_r;
    logic             err_nxt_s;
    logic             busy_r;
    logic             accept_s;
    logic             apply_s;
    logic             div_ok_s;
    logic             run_s;
    logic             run_nxt_s;
    logic             wrap_s;
    logic [CNT_W-1:0] cnt_s;
    logic             clk_s;
    logic             tick_s;

    // Next-state logic: disable and stop only take effect at period ends
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (en_in) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (!en_in) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (en_in) begin
                    state_nxt_s = RUN;
                end else if (wrap_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Counter run qualifiers derived from current and next state
    always_comb begin
        run_s     = (state_r != IDLE);
        run_nxt_s = (state_nxt_s != IDLE);
    end

    // Divisor handshake, pending register and boundary-aligned apply
    always_comb begin
        accept_s       = div_valid_in && ready_r;
        div_ok_s       = div_ok(32'(div_in));
        apply_s        = pending_r && ((state_r == IDLE) || wrap_s);
        pending_nxt_s  = pending_r;
        pend_div_nxt_s = pend_div_r;
        div_cur_nxt_s  = div_cur_r;
        err_nxt_s      = accept_s && !div_ok_s;
        if (apply_s) begin
            // Apply and accept are exclusive: accept needs pending clear
            div_cur_nxt_s = pend_div_r;
            pending_nxt_s = 1'b0;
        end else if (accept_s && div_ok_s) begin
            pend_div_nxt_s = div_in;
            pending_nxt_s  = 1'b1;
        end else begin
            pending_nxt_s  = pending_r;
            pend_div_nxt_s = pend_div_r;
        end
    end

    // State, handshake and status registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pending_r  <= 1'b0;
            pend_div_r <= DIV_RST;
            div_cur_r  <= DIV_RST;
            ready_r    <= 1'b1;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pending_r  <= pending_nxt_s;
            pend_div_r <= pend_div_nxt_s;
            div_cur_r  <= div_cur_nxt_s;
            ready_r    <= !pending_nxt_s;
            err_r      <= err_nxt_s;
            busy_r     <= run_nxt_s;
        end
    end

    clk_div_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .run      (run_s),
        .run_next (run_nxt_s),
        .div      (div_cur_r),
        .wrap     (wrap_s),
        .cnt      (cnt_s),
        .clk_out  (clk_s),
        .tick_out (tick_s)
    );

    assign div_ready_out = ready_r;
    assign div_cur_out   = div_cur_r;
    assign clk_out       = clk_s;
    assign tick_out      = tick_s;
    assign busy_out      = busy_r;
    assign err_out       = err_r;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: hand-computed vector table,
// directed corner sequences and randomized traffic against a period model.
module tb_clk_div_ctrl;

    localparam int W = 16;

    logic         clk_in = 1'b0;
    logic         rst_n = 1'b0;
    logic         en_in = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         div_valid_in = 1'b0;
    logic         div_ready_out;
    logic [W-1:0] div_cur_out;
    logic         clk_out;
    logic         tick_out;
    logic         busy_out;
    logic         err_out;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: period position, active/draining flags, divisor in use and pending request
    int m_act, m_drain, m_pos, m_n, m_pv, m_pd;
    bit m_clk, m_tick, m_err;

    typedef struct {
        bit en; int d; bit v;
        bit clk; bit tick; bit busy; bit rdy; bit err; int cur;
    } vec_t;
    vec_t tbl[16];

    always #25 clk_in = ~clk_in;

    clk_div_ctrl #(.CNT_W(W), .DEFAULT_DIV(2)) dut (
        .clk_in        (clk_in),
        .rst_n         (rst_n),
        .en_in         (en_in),
        .div_in        (div_in),
        .div_valid_in  (div_valid_in),
        .div_ready_out (div_ready_out),
        .div_cur_out   (div_cur_out),
        .clk_out       (clk_out),
        .tick_out      (tick_out),
        .busy_out      (busy_out),
        .err_out       (err_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_act = 0; m_drain = 0; m_pos = 0; m_n = 2; m_pv = 0; m_pd = 0;
        m_clk = 0; m_tick = 0; m_err = 0;
    endfunction

    // One clk_in edge of the spec's behaviour in terms of periods
    function automatic void model_step(bit en, int d, bit v);
        bit acc, bnd;
        acc   = v && (m_pv == 0);
        bnd   = (m_act != 0) && (m_pos == m_n - 1);
        m_err = acc && (d < 2);
        if ((m_pv != 0) && ((m_act == 0) || bnd)) begin
            m_n = m_pd; m_pv = 0;
        end else if (acc && d >= 2) begin
            m_pd = d; m_pv = 1;
        end
        if (m_act == 0) begin
            if (en) begin
                m_act = 1; m_drain = 0; m_pos = 0; m_clk = 1; m_tick = 1;
            end else begin
                m_pos = 0; m_clk = 0; m_tick = 0;
            end
        end else if (bnd && (m_drain != 0) && !en) begin
            m_act = 0; m_pos = 0; m_clk = 0; m_tick = 0;
        end else begin
            m_drain = en ? 0 : 1;
            m_pos   = bnd ? 0 : m_pos + 1;
            m_tick  = (m_pos == 0);
            m_clk   = (m_pos < m_n / 2);
        end
    endfunction

    task automatic check_model();
        chk("clk_out",   32'(clk_out),       32'(m_clk));
        chk("tick_out",  32'(tick_out),      32'(m_tick));
        chk("busy_out",  32'(busy_out),      32'(m_act != 0));
        chk("err_out",   32'(err_out),       32'(m_err));
        chk("div_ready", 32'(div_ready_out), 32'(m_pv == 0));
        chk("div_cur",   32'(div_cur_out),   32'(m_n));
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, sample at the next falling edge
    task automatic step(input bit en, input int d, input bit v, input bit use_model);
        en_in        = en;
        div_in       = d[W-1:0];
        div_valid_in = v;
        @(posedge clk_in);
        model_step(en, d, v);
        @(negedge clk_in);
        div_valid_in = 1'b0;
        if (use_model) check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en_in = 1'b0; div_valid_in = 1'b0; div_in = '0;
        repeat (10) @(negedge clk_in);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_busy",    32'(busy_out), 32'd0);
        chk("rst_div_cur", 32'(div_cur_out), 32'd2);
        chk("rst_ready",   32'(div_ready_out), 32'd1);
        chk("rst_tick",    32'(tick_out), 32'd0);
        chk("rst_err",     32'(err_out), 32'd0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int ticks, rises, highs, cyc;
        bit prev_clk;
        bit found;

        // en, d, v | clk, tick, busy, rdy, err, cur
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 1, 0, 2};
        tbl[1]  = '{1, 0, 0, 1, 1, 1, 1, 0, 2};
        tbl[2]  = '{1, 0, 0, 0, 0, 1, 1, 0, 2};
        tbl[3]  = '{1, 0, 0, 1, 1, 1, 1, 0, 2};
        tbl[4]  = '{1, 1, 1, 0, 0, 1, 1, 1, 2};
        tbl[5]  = '{1, 0, 0, 1, 1, 1, 1, 0, 2};
        tbl[6]  = '{1, 3, 1, 0, 0, 1, 0, 0, 2};
        tbl[7]  = '{1, 0, 0, 1, 1, 1, 1, 0, 3};
        tbl[8]  = '{1, 0, 0, 0, 0, 1, 1, 0, 3};
        tbl[9]  = '{1, 0, 0, 0, 0, 1, 1, 0, 3};
        tbl[10] = '{1, 0, 0, 1, 1, 1, 1, 0, 3};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 1, 0, 3};
        tbl[12] = '{0, 0, 0, 0, 0, 1, 1, 0, 3};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 0, 3};
        tbl[14] = '{0, 0, 1, 0, 0, 0, 1, 1, 3};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 1, 0, 3};

        do_reset();

        // Hand-computed vector table
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].en, tbl[i].d, tbl[i].v, 1'b0);
            chk($sformatf("tbl%0d_clk", i),  32'(clk_out),       32'(tbl[i].clk));
            chk($sformatf("tbl%0d_tick", i), 32'(tick_out),      32'(tbl[i].tick));
            chk($sformatf("tbl%0d_busy", i), 32'(busy_out),      32'(tbl[i].busy));
            chk($sformatf("tbl%0d_rdy", i),  32'(div_ready_out), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_err", i),  32'(err_out),       32'(tbl[i].err));
            chk($sformatf("tbl%0d_cur", i),  32'(div_cur_out),   32'(tbl[i].cur));
        end

        // Default divide-by-2 for 100 cycles: 50 ticks, 50 rising edges, 50% duty
        do_reset();
        ticks = 0; rises = 0; highs = 0; prev_clk = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 0, 1'b0, 1'b1);
            if (tick_out) ticks++;
            if (clk_out && !prev_clk) rises++;
            if (clk_out) highs++;
            prev_clk = clk_out;
        end
        chk("div2_ticks", 32'(ticks), 32'd50);
        chk("div2_rises", 32'(rises), 32'd50);
        chk("div2_highs", 32'(highs), 32'd50);

        // Retune 2 -> 4 mid-period; ready drops while pending
        step(1'b1, 4, 1'b1, 1'b1);
        chk("retune_ready_low", 32'(div_ready_out), 32'd0);
        for (int i = 0; i < 12; i++) step(1'b1, 0, 1'b0, 1'b1);
        chk("retune_cur4", 32'(div_cur_out), 32'd4);

        // Rejected divisors 1 and 0
        step(1'b1, 1, 1'b1, 1'b1);
        chk("err_div1", 32'(err_out), 32'd1);
        step(1'b1, 0, 1'b1, 1'b1);
        chk("err_div0", 32'(err_out), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b1, 0, 1'b0, 1'b1);
        chk("err_cur_kept", 32'(div_cur_out), 32'd4);

        // N=5, drop enable at cnt=1, drain to idle
        step(1'b1, 5, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_n == 5 && m_pos == 1) found = 1'b1;
            else step(1'b1, 0, 1'b0, 1'b1);
        end
        if (!found) chk("timeout_n5", 32'd1, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 0, 1'b0, 1'b1);
            if (m_act == 0) found = 1'b1;
        end
        chk("drain_idle_busy", 32'(busy_out), 32'd0);
        chk("drain_idle_clk", 32'(clk_out), 32'd0);
        // Re-raise enable during drain: no gap
        step(1'b1, 0, 1'b0, 1'b1);
        step(1'b1, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 0, 1'b0, 1'b1);
            chk("redrain_busy", 32'(busy_out), 32'd1);
        end

        // Accept divisor 3 on the exact boundary cycle while N=4
        step(1'b1, 4, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_n == 4 && m_pos == 3 && m_pv == 0) found = 1'b1;
            else step(1'b1, 0, 1'b0, 1'b1);
        end
        if (!found) chk("timeout_n4", 32'd1, 32'd0);
        step(1'b1, 3, 1'b1, 1'b1);
        chk("bnd_cur_still4", 32'(div_cur_out), 32'd4);
        cyc = 0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b1, 0, 1'b0, 1'b1);
            cyc++;
            if (tick_out) found = 1'b1;
        end
        chk("bnd_period4", 32'(cyc), 32'd4);
        chk("bnd_cur3", 32'(div_cur_out), 32'd3);

        // Randomized traffic against the model
        begin
            bit ren;
            ren = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 9) == 0) ren = ~ren;
                step(ren, int'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0), 1'b1);
            end
        end

        // Asynchronous reset while clk_out is high
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (clk_out) found = 1'b1;
            else step(1'b1, 0, 1'b0, 1'b1);
        end
        if (!found) chk("timeout_rst_high", 32'd1, 32'd0);
        #5 rst_n = 1'b0;
        #1;
        chk("async_rst_clk", 32'(clk_out), 32'd0);
        chk("async_rst_busy", 32'(busy_out), 32'd0);
        chk("async_rst_cur", 32'(div_cur_out), 32'd2);
        chk("async_rst_ready", 32'(div_ready_out), 32'd1);
        @(negedge clk_in);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
